rns_base_ext_arbiter: RTL and testbench
=======================================

Name: rns_base_ext_arbiter

Overview:
- Round-robin arbiter and pipeline sequencer that shares one combinational base-extension unit (moduli {32,31,63} -> 7-bit extended residue) among N_REQ requesting PE lanes in the RNS DNN datapath.
- Accepts residue triples over valid/ready and registers the selected triple into stage S1, which drives the unit.
- Captures the unit result in stage S2 and presents it on one tagged output channel with backpressure.
- Also flags non-canonical residues and counts issued operations.

Parameters:
N_REQ, 4, number of requesters (2..8)
TAG_W, 2, requester-index width, equal to clog2(N_REQ)
CNT_W, 16, width of the issued-operation counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
req_valid  in  N_REQ  per-lane request valid
req_ready  out  N_REQ  per-lane accept (one-hot or zero)
req_r1  in  5*N_REQ  residue mod 32, lane i at [5i+4:5i]
req_r2  in  5*N_REQ  residue mod 31, lane i at [5i+4:5i]
req_r3  in  6*N_REQ  residue mod 63, lane i at [6i+5:6i]
be_r1  out  5  to base-extension unit r1 (S1 register)
be_r2  out  5  to unit r2 (S1 register)
be_r3  out  6  to unit r3 (S1 register)
be_out  in  7  combinational result from unit
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  7  extended residue
out_tag  out  TAG_W  originating lane index
out_err  out  1  operand was non-canonical (r2==31 or r3==63)
issue_cnt  out  CNT_W  number of accepted requests, wraps
idle  out  1  no request pending, S1 and S2 empty

Behaviour:
- Reset (rst=1 at edge): all of the following clear to 0.
  - s1_valid, S1 operands (so be_r1/be_r2/be_r3 = 0), s1_tag, s1_err.
  - out_valid, out_data, out_tag, out_err.
  - issue_cnt, round-robin pointer ptr.
- Reset mid-operation discards in-flight S1/S2 contents; no output is produced for them.
- Stall logic, combinational:
  - s2_en = !out_valid | out_ready
  - s1_en = !s1_valid | s2_en
- Arbitration, combinational:
  - Search lanes ptr, ptr+1, ..., ptr+N_REQ-1 mod N_REQ; the first lane with req_valid=1 is the winner.
  - req_ready[winner] = s1_en; all other req_ready bits are 0.
  - No req_valid set -> req_ready = 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready, and must hold their data until accepted.
- Accept (req_valid[g] & req_ready[g]) at an edge:
  - S1 <= lane g operands; s1_tag <= g; s1_err <= (r2==31)|(r3==63).
  - s1_valid <= 1.
  - ptr <= (g+1) mod N_REQ.
  - issue_cnt <= issue_cnt+1, wrapping to 0 past all-ones.
- No accept while s1_en=1: s1_valid <= 0 and ptr holds.
- s1_en=0: S1 holds unchanged.
- S2 when s2_en=1:
  - out_valid <= s1_valid.
  - If s1_valid: out_data <= be_out, out_tag <= s1_tag, out_err <= s1_err.
- S2 when s2_en=0: all S2 outputs hold stable.
- Latency and throughput:
  - Accept at edge t -> out_valid=1 after edge t+1, assuming no stall.
  - Throughput is 1 result/cycle while out_ready=1.
  - A full pipeline with out_ready=0 holds 2 entries and drives req_ready=0.
- Simultaneous events:
  - An S2 drain and an S1 refill in the same cycle are legal; there is no bubble.
  - A lane requesting every cycle gets at most 1 of every N_REQ grants when all lanes request.
- Non-canonical operands are still passed to the unit; out_err only marks them.
- idle = !(|req_valid) & !s1_valid & !out_valid.

Test Plan:
- Reset, then lane 0 sends r1=4, r2=7, r3=37 (X=100), out_ready=1 -> req_ready[0]=1 one cycle; two edges later out_valid=1, out_data=100, out_tag=0, out_err=0; issue_cnt=1.
- All 4 lanes valid continuously, out_ready=1, ptr=0 -> grants 0,1,2,3,0,... one per cycle; out_tag sequence matches; 8 results in 8 consecutive cycles after the 2-cycle fill.
- Lanes 1,3 valid with out_ready=0 -> exactly 2 accepts (lane1 then lane3); req_ready=0 afterwards; out_data/out_tag stable. Raise out_ready -> both drain in order, no loss or duplication.
- Lane 2 sends r2=31, r3=5, r1=0 -> out_err=1, out_tag=2. Lane 2 sends r3=63 -> out_err=1. A canonical triple -> out_err=0.
- Assert rst while S1 and S2 are full -> next cycle out_valid=0, be_r*=0, issue_cnt=0, ptr=0, idle=1 when no req_valid; first post-reset grant goes to lowest valid lane.
- Drive 2^CNT_W+3 accepts -> issue_cnt=3. Single lane requesting alone -> grant every cycle regardless of ptr.

Source files
------------

// File: rtl/rns_base_ext_arbiter.sv
// Round-robin arbiter feeding a shared combinational base-extension unit
// through a two-stage (S1 operand / S2 result) pipeline with backpressure.
module rns_base_ext_arbiter #(
  parameter int N_REQ = 4,
  parameter int TAG_W = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [5*N_REQ-1:0] req_r1,
  input  logic [5*N_REQ-1:0] req_r2,
  input  logic [6*N_REQ-1:0] req_r3,
  output logic [4:0]         be_r1,
  output logic [4:0]         be_r2,
  output logic [5:0]         be_r3,
  input  logic [6:0]         be_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6:0]         out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err,
  output logic [CNT_W-1:0]   issue_cnt,
  output logic               idle
);

  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_err;
  logic [TAG_W-1:0] ptr;

  logic             s1_en;
  logic             s2_en;
  logic             grant_found;
  logic [TAG_W-1:0] grant_idx;
  int unsigned      lane;
  logic             accept;
  logic [4:0]       sel_r1;
  logic [4:0]       sel_r2;
  logic [5:0]       sel_r3;
  logic             sel_err;

  assign s2_en = !out_valid || out_ready;
  assign s1_en = !s1_valid || s2_en;

  // Rotating priority: scan from ptr upwards, wrapping at N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    lane        = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      lane = (int'(ptr) + k) % N_REQ;
      if (!grant_found && req_valid[lane]) begin
        grant_found = 1'b1;
        grant_idx   = TAG_W'(lane);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_idx] = s1_en;
  end

  assign accept  = grant_found && s1_en;
  assign sel_r1  = req_r1[int'(grant_idx)*5 +: 5];
  assign sel_r2  = req_r2[int'(grant_idx)*5 +: 5];
  assign sel_r3  = req_r3[int'(grant_idx)*6 +: 6];
  assign sel_err = (sel_r2 == 5'd31) || (sel_r3 == 6'd63);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      be_r1     <= '0;
      be_r2     <= '0;
      be_r3     <= '0;
      s1_tag    <= '0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      issue_cnt <= '0;
      ptr       <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= accept;
        if (accept) begin
          be_r1     <= sel_r1;
          be_r2     <= sel_r2;
          be_r3     <= sel_r3;
          s1_tag    <= grant_idx;
          s1_err    <= sel_err;
          ptr       <= TAG_W'((int'(grant_idx) + 1) % N_REQ);
          issue_cnt <= issue_cnt + CNT_W'(1);
        end
      end
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= be_out;
          out_tag  <= s1_tag;
          out_err  <= s1_err;
        end
      end
    end
  end

  assign idle = !(|req_valid) && !s1_valid && !out_valid;

endmodule

// File: tb/tb_rns_base_ext_arbiter.sv
// Directed bench for rns_base_ext_arbiter with a CRT-based model of the
// base-extension unit ({32,31,63} -> X mod 128).
module tb_rns_base_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [19:0] req_r1;
  logic [19:0] req_r2;
  logic [23:0] req_r3;
  logic [4:0]  be_r1;
  logic [4:0]  be_r2;
  logic [5:0]  be_r3;
  logic [6:0]  be_out;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_data;
  logic [1:0]  out_tag;
  logic        out_err;
  logic [15:0] issue_cnt;
  logic        idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rns_base_ext_arbiter #(.N_REQ(4), .TAG_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_r1(req_r1), .req_r2(req_r2), .req_r3(req_r3),
    .be_r1(be_r1), .be_r2(be_r2), .be_r3(be_r3), .be_out(be_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_err(out_err),
    .issue_cnt(issue_cnt), .idle(idle)
  );

  // CRT weights: 1953*1, 2016*1, 992*59 modulo 62496.
  function automatic logic [6:0] crt(input logic [4:0] a, input logic [4:0] b, input logic [5:0] c);
    int unsigned x;
    x = (int'(a) * 1953 + int'(b) * 2016 + int'(c) * 992 * 59) % 62496;
    return x[6:0];
  endfunction

  always_comb be_out = crt(be_r1, be_r2, be_r3);

  task automatic set_lane(input int l, input logic [4:0] a, input logic [4:0] b, input logic [5:0] c);
    req_r1[5*l +: 5] = a;
    req_r2[5*l +: 5] = b;
    req_r3[6*l +: 6] = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; out_ready = 1'b1;
    req_r1 = '0; req_r2 = '0; req_r3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, be_r1, be_r2, be_r3, issue_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b be=%0d/%0d/%0d cnt=%0d, want all 0", out_valid, be_r1, be_r2, be_r3, issue_cnt);
    end
    checks++;
    if (idle !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: idle=%b req_ready=%b, want 1 0000", idle, req_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_lane(0, 5'd4, 5'd7, 6'd37);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (be_r1 !== 5'd4 || be_r2 !== 5'd7 || be_r3 !== 6'd37 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_s1: be=%0d/%0d/%0d out_valid=%b want 4/7/37 0", be_r1, be_r2, be_r3, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 7'd100 || out_tag !== 2'd0 || out_err !== 1'b0 || issue_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_out: v=%b d=%0d t=%0d e=%b cnt=%0d want 1 100 0 0 1", out_valid, out_data, out_tag, out_err, issue_cnt);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] want_ready;
    logic [1:0] want_tag;
    logic [4:0] a;
    do_reset();
    for (int l = 0; l < 4; l++) set_lane(l, 5'(l + 1), 5'(l + 2), 6'(l + 3));
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) begin
        want_ready = 4'b0001 << (c % 4);
        checks++;
        if (req_ready !== want_ready) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, want_ready); end
      end
      if (c >= 2) begin
        want_tag = 2'((c - 2) % 4);
        a = 5'(want_tag) + 5'd1;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== want_tag || out_data !== crt(a, a + 5'd1, 6'(a) + 6'd2)) begin
          errors++;
          $display("FAIL rr_out[%0d]: v=%b t=%0d d=%0d want 1 %0d %0d", c, out_valid, out_tag, out_data, want_tag, crt(a, a + 5'd1, 6'(a) + 6'd2));
        end
      end
    end
    checks++;
    if (issue_cnt !== 16'd8) begin errors++; $display("FAIL rr_count: got %0d want 8", issue_cnt); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_lane(1, 5'd10, 5'd20, 6'd30);
    set_lane(3, 5'd11, 5'd21, 6'd40);
    out_ready = 1'b0;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first: got %b want 0010", req_ready); end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_second: got %b want 1000", req_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_tag !== 2'd1 ||
          out_data !== crt(5'd10, 5'd20, 6'd30) || issue_cnt !== 16'd10) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rdy=%b v=%b t=%0d d=%0d cnt=%0d want 0000 1 1 %0d 10", c, req_ready, out_valid, out_tag, out_data, issue_cnt, crt(5'd10, 5'd20, 6'd30));
      end
    end
    req_valid = '0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 2'd3 || out_data !== crt(5'd11, 5'd21, 6'd40)) begin
      errors++;
      $display("FAIL bp_drain: v=%b t=%0d d=%0d want 1 3 %0d", out_valid, out_tag, out_data, crt(5'd11, 5'd21, 6'd40));
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || idle !== 1'b1 || issue_cnt !== 16'd10) begin
      errors++;
      $display("FAIL bp_empty: v=%b idle=%b cnt=%0d want 0 1 10", out_valid, idle, issue_cnt);
    end
  endtask

  task automatic send_one(input int l, input logic [4:0] a, input logic [4:0] b, input logic [5:0] c, input logic want_err);
    @(negedge clk);
    set_lane(l, a, b, c);
    req_valid = 4'b0001 << l;
    #1;
    checks++;
    if (req_ready !== (4'b0001 << l)) begin errors++; $display("FAIL err_ready: got %b want %b", req_ready, 4'b0001 << l); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 2'(l) || out_err !== want_err || out_data !== crt(a, b, c)) begin
      errors++;
      $display("FAIL err_out: v=%b t=%0d e=%b d=%0d want 1 %0d %b %0d", out_valid, out_tag, out_err, out_data, l, want_err, crt(a, b, c));
    end
  endtask

  task automatic test_err();
    out_ready = 1'b1;
    send_one(2, 5'd0, 5'd31, 6'd5, 1'b1);
    send_one(2, 5'd3, 5'd4, 6'd63, 1'b1);
    send_one(2, 5'd4, 5'd7, 6'd37, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0;
    set_lane(0, 5'd1, 5'd2, 6'd3);
    set_lane(2, 5'd5, 5'd6, 6'd7);
    req_valid = 4'b0101;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_full: v=%b rdy=%b want 1 0000", out_valid, req_ready);
    end
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {be_r1, be_r2, be_r3} !== '0 || issue_cnt !== 16'd0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_clear: v=%b be=%0d/%0d/%0d cnt=%0d idle=%b want 0 0/0/0 0 1", out_valid, be_r1, be_r2, be_r3, issue_cnt, idle);
    end
    set_lane(1, 5'd9, 5'd8, 6'd7);
    set_lane(3, 5'd2, 5'd2, 6'd2);
    req_valid = 4'b1110;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstmid_ptr: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_discard: out_valid=%b want 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_data !== crt(5'd9, 5'd8, 6'd7)) begin
      errors++;
      $display("FAIL rstmid_first: v=%b t=%0d d=%0d want 1 1 %0d", out_valid, out_tag, out_data, crt(5'd9, 5'd8, 6'd7));
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b1;
    set_lane(2, 5'd6, 5'd6, 6'd6);
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 0100", c, req_ready); end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_counter_wrap();
    int misses;
    misses = 0;
    do_reset();
    out_ready = 1'b1;
    set_lane(0, 5'd1, 5'd1, 6'd1);
    req_valid = 4'b0001;
    for (int c = 0; c < 65539; c++) begin
      #1;
      if (req_ready !== 4'b0001) misses++;
      @(negedge clk);
    end
    req_valid = '0;
    checks++;
    if (misses != 0) begin errors++; $display("FAIL single_lane_every_cycle: misses=%0d want 0", misses); end
    checks++;
    if (issue_cnt !== 16'd3) begin errors++; $display("FAIL cnt_wrap: got %0d want 3", issue_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_err();
    test_reset_mid();
    test_back_to_back();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
